// File: rtl/spline_segment_feeder_pkg.sv
// Shared widths, FSM encoding and slope saturation limits for the spline segment feeder.
package spline_segment_feeder_pkg;

    localparam int PW   = 16;
    localparam int VW   = 20;
    localparam int FRAC = 4;
    localparam int DW   = VW + 1 + FRAC;

    localparam int VMAX_MAG = 2**(VW-1) - 1;
    localparam int VMIN_MAG = 2**(VW-1);
    localparam logic signed [VW-1:0] VMAX = VW'(VMAX_MAG);
    localparam logic signed [VW-1:0] VMIN = VW'(VMIN_MAG);

    typedef enum logic [1:0] {
        IDLE,
        ANCHORED,
        DIVIDE,
        SWEEP
    } state_t;

endpackage

// File: rtl/spline_segment_feeder_div.sv
// Unsigned restoring divider, one quotient bit per clock, fixed DW-cycle latency.
module seg_slope_div
    import spline_segment_feeder_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [PW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient
);

    localparam int CW = $clog2(DW + 1);

    logic [PW-1:0] rem;
    logic [PW-1:0] dvs;
    logic [CW-1:0] cnt;
    logic [PW:0]   trial;

    // Dividend bits shift out of the top of the quotient register as quotient bits shift in.
    assign trial = {rem, quotient[DW-1]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient <= dividend;
                rem      <= '0;
                dvs      <= divisor;
                cnt      <= CW'(DW);
                busy     <= 1'b1;
            end else if (busy) begin
                if (trial >= {1'b0, dvs}) begin
                    rem      <= PW'(trial - {1'b0, dvs});
                    quotient <= {quotient[DW-2:0], 1'b1};
                end else begin
                    rem      <= trial[PW-1:0];
                    quotient <= {quotient[DW-2:0], 1'b0};
                end
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spline_segment_feeder.sv
// Builds linear spline segments from consecutive extrema and sweeps x across each one.
module spline_segment_feeder
    import spline_segment_feeder_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 ext_valid,
    output logic                 ext_ready,
    input  logic [PW-1:0]        ext_pos,
    input  logic signed [VW-1:0] ext_val,
    output logic signed [VW-1:0] A,
    output logic signed [VW-1:0] B,
    output logic signed [VW-1:0] C,
    output logic signed [VW-1:0] D,
    output logic [VW-1:0]        P1,
    output logic [VW-1:0]        P2,
    output logic signed [PW-1:0] x,
    output logic                 x_valid,
    output logic                 flat_seg,
    output logic                 seg_done,
    output logic                 follow_start,
    output logic                 err_order
);

    state_t               state;
    logic [PW-1:0]        prev_pos;
    logic [PW-1:0]        end_pos;
    logic [PW-1:0]        x_cnt;
    logic signed [VW-1:0] prev_val;
    logic signed [VW-1:0] end_val;
    logic                 neg;

    logic                 take;
    logic                 seg_start;
    logic signed [VW:0]   dy;
    logic [VW:0]          dy_mag;
    logic [DW-1:0]        dividend;
    logic [PW-1:0]        divisor;
    logic                 div_busy;
    logic                 div_done;
    logic [DW-1:0]        quo;
    logic signed [VW-1:0] slope;

    assign ext_ready = (state == IDLE) || (state == ANCHORED);
    assign take      = ext_valid && ext_ready;
    assign seg_start = take && (state == ANCHORED) && (ext_pos > prev_pos);

    // Divider is launched on the accepting edge itself so B is ready 26 edges later.
    assign dy       = {ext_val[VW-1], ext_val} - {prev_val[VW-1], prev_val};
    assign dy_mag   = dy[VW] ? -dy : dy;
    assign dividend = {dy_mag, {FRAC{1'b0}}};
    assign divisor  = ext_pos - prev_pos;

    assign C = '0;
    assign D = '0;
    assign x = $signed(x_cnt);

    seg_slope_div u_div (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (seg_start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo)
    );

    always_comb begin
        slope = '0;
        if (neg)
            slope = (quo > DW'(VMIN_MAG)) ? VMIN : -$signed(quo[VW-1:0]);
        else
            slope = (quo > DW'(VMAX_MAG)) ? VMAX : $signed(quo[VW-1:0]);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= IDLE;
            prev_pos     <= '0;
            prev_val     <= '0;
            end_pos      <= '0;
            end_val      <= '0;
            neg          <= 1'b0;
            A            <= '0;
            B            <= '0;
            P1           <= '0;
            P2           <= '0;
            x_cnt        <= '0;
            x_valid      <= 1'b0;
            flat_seg     <= 1'b0;
            seg_done     <= 1'b0;
            follow_start <= 1'b0;
            err_order    <= 1'b0;
        end else begin
            err_order <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        prev_pos <= ext_pos;
                        prev_val <= ext_val;
                        state    <= ANCHORED;
                    end
                end
                ANCHORED: begin
                    if (seg_start) begin
                        end_pos <= ext_pos;
                        end_val <= ext_val;
                        neg     <= dy[VW];
                        state   <= DIVIDE;
                    end else if (take) begin
                        err_order <= 1'b1;
                    end
                end
                DIVIDE: begin
                    if (div_done) begin
                        A            <= prev_val;
                        B            <= slope;
                        flat_seg     <= (slope == '0);
                        P1           <= VW'(prev_pos);
                        P2           <= VW'(end_pos);
                        x_cnt        <= prev_pos;
                        x_valid      <= 1'b1;
                        seg_done     <= (end_pos - prev_pos == PW'(1));
                        follow_start <= 1'b1;
                        state        <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (seg_done) begin
                        x_valid  <= 1'b0;
                        seg_done <= 1'b0;
                        prev_pos <= end_pos;
                        prev_val <= end_val;
                        state    <= ANCHORED;
                    end else begin
                        x_cnt    <= x_cnt + PW'(1);
                        seg_done <= (x_cnt + PW'(2) == end_pos);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spline_segment_feeder.md
Name: spline_segment_feeder

Overview:
- Producer side of the spline interpolator interface: it builds the segments the interpolator consumes.
- Accepts a stream of extrema points (sample position, value) from the extrema detector.
- For each adjacent pair, computes the linear-segment coefficients A, B (slope, Q4 fixed point), C, D, P1, P2.
- Sweeps the sample index x across the segment, one step per clock, with start/done signalling for the interpolator and downstream EMD stages.

Parameters:
- PW, 16, position/x width (unsigned positions, x driven as signed 16).
- VW, 20, value/coefficient width (signed).
- FRAC, 4, slope fraction bits (B = 16*dY/dP).

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- ext_valid  in  1  extremum point offered
- ext_ready  out  1  block can accept a point
- ext_pos  in  PW  point position (sample index)
- ext_val  in  VW  point value, signed
- A  out  VW  segment start value (= previous point value)
- B  out  VW  slope, signed, Q(VW-FRAC).FRAC
- C  out  VW  cubic coefficient, driven 0 in this revision
- D  out  VW  cubic coefficient, driven 0 in this revision
- P1  out  VW  segment start position, zero-extended
- P2  out  VW  segment end position, zero-extended
- x  out  PW  current sample index, signed
- x_valid  out  1  x is a live sweep sample
- flat_seg  out  1  current segment has B==0; interpolator passes the delayed input through
- seg_done  out  1  one-cycle pulse on the last sample of a segment
- follow_start  out  1  sticky; set on the first sweep cycle after reset
- err_order  out  1  one-cycle pulse when a point is dropped

Behaviour:
- Reset values (async on RST_N low): A, B, C, D, P1, P2, x = 0; x_valid, flat_seg, seg_done, follow_start, err_order = 0; ext_ready = 1; state = IDLE; anchor cleared.
- Handshake: a point transfers on a rising edge with ext_valid && ext_ready. ext_ready is high only in IDLE and ANCHORED.
- IDLE:
  - A transfer stores the point as the anchor (prevPos, prevVal). No segment is produced.
  - Next state: ANCHORED.
- ANCHORED:
  - A transfer with ext_pos <= prevPos is dropped: err_order pulses on the next cycle, state stays, anchor is unchanged.
  - Otherwise, latch dP = ext_pos - prevPos (unsigned, >= 1) and dY = ext_val - prevVal (VW+1 bits). Next state: DIVIDE.
- DIVIDE:
  - Signed dividend dY*2^FRAC (VW+1+FRAC = 25 bits).
  - Division runs on magnitudes, restoring, 1 quotient bit per clock, 25 cycles.
  - Sign is reapplied afterwards; the quotient truncates toward zero.
  - The result saturates to [-2^(VW-1), 2^(VW-1)-1].
  - Next state: SWEEP.
- SWEEP:
  - Latency: if the point transfers at edge k, then from edge k+26 the outputs are valid: A = prevVal, B, C = D = 0, P1 = prevPos, P2 = ext_pos, x = P1, x_valid = 1.
  - flat_seg = (B == 0).
  - follow_start is set at the first SWEEP cycle after reset and then stays set.
  - x increments by 1 each clock and reaches P2-1 after dP cycles.
  - seg_done is high in the same cycle that x == P2-1.
  - On the next edge: the anchor becomes (P2, ext_val), x_valid drops, A/B/P1/P2/x hold their last values, state returns to ANCHORED.
- x has no wrap-around. Positions are strictly increasing, and PW bounds them at 65535.
- No new point is accepted during DIVIDE or SWEEP (ext_ready = 0). An upstream ext_valid held high waits.
- Reset asserted mid-DIVIDE or mid-SWEEP aborts immediately. All outputs return to reset values, the anchor is lost, and the next point re-anchors.

Decomposition:
- Shared package holds:
  - width constants PW, VW, FRAC;
  - the state encoding (IDLE, ANCHORED, DIVIDE, SWEEP);
  - saturation limits VMAX and VMIN.
- One sub-module: seg_slope_div, a sequential unsigned restoring divider.
  - Ports: start, dividend[24:0], divisor[15:0], busy, done, quotient[24:0].
  - Fixed 25-cycle latency.
- The top module handles sign, saturation, the FSM and the x counter.

Test Plan:
- Points (0,0) then (16,256): B = 256, A = 0, P1 = 0, P2 = 16, x sweeps 0..15 from edge k+26, seg_done with x = 15, follow_start becomes 1.
- Continue with (20,0): dY = -256, dP = 4, B = -1024, A = 256, P1 = 16, x = 16..19, seg_done at 19.
- Points (0,0) then (3,1): B = 16/3 = 5, which checks truncation. Points (0,0) then (3,-1): B = -5.
- Points (0,-524288) then (1,524287): the quotient overflows, so B saturates to 524287. The reverse order (0,524287) then (1,-524288) gives B = -524288.
- Anchor (10,5), then offer (10,7) and (8,7): both are dropped with one err_order pulse each. Offer (14,5): B = 0, flat_seg = 1, x = 10..13.
- Assert RST_N low at x = 5 during the sweep of the first test: all outputs go to 0 at once and ext_ready = 1. The next point (100,0) only anchors and produces no x_valid.
